// File: rtl/fp_ln_seq.sv
// fp_ln_seq: sequential IEEE754 single-precision natural logarithm.
// Shift-and-add iteration over a ln(1+2^-k) ROM, one step per clock,
// start/done handshake. Result is (e+1)*ln2 - acc, normalised and rounded
// to nearest even.
module fp_ln_seq #(
    parameter int ITER = 24,
    parameter int FRAC = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    localparam int W  = FRAC + 2;   // unsigned Q2.FRAC mantissa / accumulator
    localparam int RW = FRAC + 10;  // signed combine result

    localparam logic [W-1:0] TWO     = {2'b10, {FRAC{1'b0}}};
    localparam logic [31:0]  LN2_Q30 = 32'd744261118;

    // ln(1+2^-k) in Q0.30, rounded to nearest
    function automatic logic [31:0] ln_tab_q30(input logic [4:0] idx);
        logic [31:0] v;
        case (idx)
            5'd1:  v = 32'd435364845;
            5'd2:  v = 32'd239598564;
            5'd3:  v = 32'd126468572;
            5'd4:  v = 32'd65095192;
            5'd5:  v = 32'd33040817;
            5'd6:  v = 32'd16647494;
            5'd7:  v = 32'd8356010;
            5'd8:  v = 32'd4186133;
            5'd9:  v = 32'd2095107;
            5'd10: v = 32'd1048064;
            5'd11: v = 32'd524160;
            5'd12: v = 32'd262112;
            5'd13: v = 32'd131064;
            5'd14: v = 32'd65534;
            5'd15: v = 32'd32768;
            5'd16: v = 32'd16384;
            5'd17: v = 32'd8192;
            5'd18: v = 32'd4096;
            5'd19: v = 32'd2048;
            5'd20: v = 32'd1024;
            5'd21: v = 32'd512;
            5'd22: v = 32'd256;
            5'd23: v = 32'd128;
            5'd24: v = 32'd64;
            5'd25: v = 32'd32;
            5'd26: v = 32'd16;
            5'd27: v = 32'd8;
            5'd28: v = 32'd4;
            5'd29: v = 32'd2;
            5'd30: v = 32'd1;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // Rescale a Q0.30 constant to Q0.FRAC
    function automatic logic [63:0] q30_to_frac(input logic [31:0] v);
        return {v, 32'd0} >> (62 - FRAC);
    endfunction

    localparam logic [RW-1:0] LN2_F = RW'(q30_to_frac(LN2_Q30));

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ITER, S_COMBINE, S_NORM, S_DONE
    } state_t;

    state_t                state, state_next;
    logic                  busy_next, done_next;
    logic [31:0]           in_r;
    logic signed [8:0]     e_r;
    logic [W-1:0]          x, acc;
    logic [4:0]            k;
    logic signed [RW-1:0]  r;
    logic [31:0]           res;

    logic                  spec_hit;
    logic [31:0]           spec_val;
    logic [W-1:0]          x_sh, t, tab;
    logic                  take;
    logic signed [8:0]     e1;
    logic signed [RW-1:0]  e1_ext, acc_ext, r_calc;
    logic [RW-1:0]         mag, norm;
    logic [7:0]            lead, ebias;
    logic [22:0]           mant;
    logic                  guard, sticky;
    logic [23:0]           mant_r;
    logic [31:0]           norm_val;

    // Special-operand classification of the captured input, in priority order
    always_comb begin
        spec_hit = 1'b1;
        spec_val = '0;
        if (in_r[30:23] == 8'hFF && in_r[22:0] != 23'd0)
            spec_val = 32'h7FC00000;
        else if (in_r[31] && in_r[30:0] != 31'd0)
            spec_val = 32'h7FC00000;
        else if (in_r[30:23] == 8'h00)
            spec_val = 32'hFF800000;
        else if (in_r[30:23] == 8'hFF)
            spec_val = 32'h7F800000;
        else if (in_r == 32'h3F800000)
            spec_val = 32'h00000000;
        else
            spec_hit = 1'b0;
    end

    // One shift-and-add step plus the combine subtraction
    always_comb begin
        x_sh    = x >> k;
        t       = x + x_sh;
        take    = (t <= TWO);
        tab     = W'(q30_to_frac(ln_tab_q30(k)));
        e1      = e_r + 9'sd1;
        e1_ext  = {{(RW-9){e1[8]}}, e1};
        acc_ext = {{(RW-W){1'b0}}, acc};
        r_calc  = e1_ext * $signed(LN2_F) - acc_ext;
    end

    // Normalise |r| to 1.23, round to nearest even; zero magnitude gives +0
    always_comb begin
        mag  = r[RW-1] ? -r : r;
        lead = '0;
        for (int unsigned i = 0; i < RW; i++)
            if (mag[i]) lead = 8'(i);
        norm   = mag << (8'(RW-1) - lead);
        mant   = norm[RW-2 -: 23];
        guard  = norm[RW-25];
        sticky = |norm[RW-26:0];
        mant_r = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
        ebias  = lead + 8'(127 - FRAC) + {7'd0, mant_r[23]};
        norm_val = norm[RW-1] ? {r[RW-1], ebias, mant_r[22:0]} : 32'h0;
    end

    // Next-state and registered-output decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_UNPACK;
            S_UNPACK:  state_next = spec_hit ? S_DONE : S_ITER;
            S_ITER:    if (k == 5'(ITER)) state_next = S_COMBINE;
            S_COMBINE: state_next = S_NORM;
            S_NORM:    state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        busy_next = (state_next != S_IDLE);
        done_next = (state == S_DONE);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_r <= '0;
            e_r  <= '0;
            x    <= '0;
            acc  <= '0;
            k    <= '0;
            r    <= '0;
            res  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            out  <= '0;
        end else begin
            busy <= busy_next;
            done <= done_next;
            case (state)
                S_IDLE: if (start) in_r <= in;
                S_UNPACK: begin
                    if (spec_hit) begin
                        res <= spec_val;
                    end else begin
                        e_r <= 9'({1'b0, in_r[30:23]} - 9'd127);
                        x   <= W'({2'b01, in_r[22:0]}) << (FRAC - 23);
                        acc <= '0;
                        k   <= 5'd1;
                    end
                end
                S_ITER: begin
                    if (take) begin
                        x   <= t;
                        acc <= acc + tab;
                    end
                    k <= k + 5'd1;
                end
                S_COMBINE: r   <= r_calc;
                S_NORM:    res <= norm_val;
                S_DONE:    out <= res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_ln_seq.sv
// Directed bench for fp_ln_seq: vector table, reset abort, busy protocol,
// back-to-back spacing and exp/ln round trip.
module tb_fp_ln_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic [31:0] dout;

    int n_cmp = 0;
    int n_bad = 0;

    fp_ln_seq #(.ITER(24), .FRAC(30)) dut (
        .clk(clk), .rst(rst), .start(start), .in(din),
        .busy(busy), .done(done), .out(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] want;
        int          tol;
        int          lat;
    } vec_t;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + $itor(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        real  m, f, fr;
        int   e, q;
        logic s;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        f  = (m - 1.0) * 8388608.0;
        q  = $rtoi(f);
        fr = f - $itor(q);
        if (fr > 0.5 || (fr == 0.5 && q[0])) q++;
        if (q == 8388608) begin q = 0; e++; end
        return {s, 8'(e + 127), q[22:0]};
    endfunction

    task automatic check_ulp(input string name, input logic [31:0] act,
                             input logic [31:0] req, input int tol);
        int d;
        d = int'({1'b0, act[30:0]}) - int'({1'b0, req[30:0]});
        if (d < 0) d = -d;
        n_cmp++;
        if (act[31] != req[31] || d > tol) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h (+/-%0d ulp)", name, act, req, tol);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic check_abs(input string name, input logic [31:0] act, input real arg);
        real err;
        err = f2r(act) - arg;
        if (err < 0.0) err = -err;
        n_cmp++;
        if (err > 9.5367431640625e-7 || act[31] != (arg < 0.0)) begin
            n_bad++;
            $display("FAIL %s: got %08h (%g), want %g within 2^-20", name, act, f2r(act), arg);
        end
    endtask

    // Issue one operation; lat is cycles from acceptance to done, -1 on timeout
    task automatic do_op(input logic [31:0] a, output logic [31:0] res, output int lat);
        din   = a;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (done) begin lat = c; break; end
        end
        res = dout;
    endtask

    vec_t        vt [13];
    real         rt_args [9];
    logic [31:0] res;
    int          lat;
    int          seen;
    logic [31:0] ops [3];
    logic [31:0] b2b_res [3];
    int          b2b_t [3];
    int          idx;

    initial begin
        vt[0]  = '{32'h3F800000, 32'h00000000, 0, 2};
        vt[1]  = '{32'h00000000, 32'hFF800000, 0, 2};
        vt[2]  = '{32'h80000000, 32'hFF800000, 0, 2};
        vt[3]  = '{32'h00000001, 32'hFF800000, 0, 2};
        vt[4]  = '{32'hBF000000, 32'h7FC00000, 0, 2};
        vt[5]  = '{32'hFF800000, 32'h7FC00000, 0, 2};
        vt[6]  = '{32'h7F800000, 32'h7F800000, 0, 2};
        vt[7]  = '{32'h7FC00001, 32'h7FC00000, 0, 2};
        vt[8]  = '{32'h40000000, 32'h3F317218, 0, 28};
        vt[9]  = '{32'h3F000000, 32'hBF317218, 2, 28};
        vt[10] = '{32'h41200000, 32'h40135D8E, 2, 28};
        vt[11] = '{32'h3DCCCCCD, 32'hC0135D8E, 2, 28};
        vt[12] = '{32'h402DF854, 32'h3F800000, 2, 28};
        rt_args = '{0.001, 0.01, 0.1, 10.0, 2.0, 1.53, 0.526, -0.526, -1.53};

        rst = 1'b1; start = 1'b0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        check_ulp("reset_out", dout, 32'h00000000, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < 13; i++) begin
            do_op(vt[i].a, res, lat);
            check_ulp($sformatf("vec%0d_out(%08h)", i, vt[i].a), res, vt[i].want, vt[i].tol);
            check_int($sformatf("vec%0d_lat", i), lat, vt[i].lat);
        end
        @(posedge clk); #1;
        check_int("done_one_cycle", int'(done), 0);

        // Reset in the middle of ITER aborts the operation
        din = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_int("busy_before_abort", int'(busy), 1);
        rst = 1'b1;
        #1;
        check_int("abort_busy", int'(busy), 0);
        check_int("abort_done", int'(done), 0);
        check_ulp("abort_out", dout, 32'h00000000, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check_int("abort_no_done", seen, 0);
        do_op(32'h40000000, res, lat);
        check_ulp("after_abort_ln2", res, 32'h3F317218, 0);
        check_int("after_abort_lat", lat, 28);
        @(posedge clk); #1;
        check_int("after_abort_done_pulse", int'(done), 0);

        // start during busy is ignored
        din = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            if (c == 5) begin din = 32'h41200000; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (done) begin lat = c; break; end
        end
        start = 1'b0;
        check_int("busy_ign_lat", lat, 28);
        check_ulp("busy_ign_out", dout, 32'h3F317218, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check_int("busy_ign_no_done", seen, 0);
        check_ulp("busy_ign_hold", dout, 32'h3F317218, 0);

        // Back-to-back: next start raised in the done cycle
        ops = '{32'h40000000, 32'h41200000, 32'h3F000000};
        b2b_t = '{-1, -1, -1};
        din = ops[0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                b2b_t[idx]   = c;
                b2b_res[idx] = dout;
                idx++;
                if (idx == 3) break;
                din = ops[idx]; start = 1'b1;
            end
        end
        start = 1'b0;
        check_int("b2b_first_lat", b2b_t[0], 28);
        check_int("b2b_gap1", b2b_t[1] - b2b_t[0], 29);
        check_int("b2b_gap2", b2b_t[2] - b2b_t[1], 29);
        check_ulp("b2b_res0", b2b_res[0], 32'h3F317218, 0);
        check_ulp("b2b_res1", b2b_res[1], 32'h40135D8E, 2);
        check_ulp("b2b_res2", b2b_res[2], 32'hBF317218, 2);

        // Round trip ln(exp(a)) == a
        for (int i = 0; i < 9; i++) begin
            do_op(r2f($exp(rt_args[i])), res, lat);
            if (rt_args[i] >= 1.0 || rt_args[i] <= -1.0)
                check_ulp($sformatf("rt%0d", i), res, r2f(rt_args[i]), 2);
            else
                check_abs($sformatf("rt%0d", i), res, rt_args[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_ln_seq.md
Name: fp_ln_seq

Overview:
- Sequential IEEE754 single-precision natural logarithm unit.
- It is the inverse companion of the combinational taylor_exp block: feeding it taylor_exp outputs returns the original arguments within tolerance.
- Uses a shift-and-add logarithm iteration over a constant table of ln(1+2^-k), one iteration per clock, with a start/done handshake.
- Intended for the NTH ROOT datapath, where the root is computed as exp(ln(x)/n).

Parameters:
- ITER, 24: number of shift-and-add iterations, k = 1..ITER. Legal range 20..30.
- FRAC, 30: fractional bits of the internal fixed-point format.

Ports:
- clk, input, 1: clock, rising-edge active.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request. Sampled only in IDLE.
- in, input, 32: IEEE754 single operand. Captured on the cycle start is accepted.
- busy, output, 1: high from the cycle after acceptance until done.
- done, output, 1: one-cycle pulse when out is valid.
- out, output, 32: IEEE754 single ln(in). Held until the next done.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, out=32'h00000000, and all internal registers cleared. Reset mid-operation aborts the operation; no done is produced.
- Acceptance: start=1 in IDLE captures in and moves to UNPACK. start while busy is ignored and does not queue.
- States:
  - IDLE
  - UNPACK
  - ITER
  - COMBINE
  - NORM
  - DONE
- UNPACK, special cases, checked in this order. Each goes directly to DONE and gives done 2 cycles after acceptance:
  - NaN in: out=7FC00000
  - sign=1 and in != -0: out=7FC00000
  - ±0 or denormal (flushed to zero): out=FF800000
  - +inf: out=7F800000
  - exactly 3F800000: out=00000000
- UNPACK, normal path:
  - e = exp-127 (signed 9-bit).
  - x = 1.mant in unsigned Q2.FRAC.
  - acc = 0, k = 1.
- ITER, one cycle per k, for k = 1..ITER:
  - t = x + (x >> k).
  - If t <= 2.0: x = t and acc += LN_TAB[k].
  - LN_TAB[k] = ln(1+2^-k) in Q0.FRAC, rounded to nearest. It is a constant ROM (case statement).
  - Go to COMBINE after k = ITER.
- COMBINE: r = (e+1)*LN2 - acc.
  - r is signed, FRAC+10 bits wide.
  - LN2 is ln2 in Q0.FRAC.
  - The multiply is a constant multiply with a 9-bit signed operand.
- NORM:
  - sign = r[msb]; magnitude = |r|.
  - Leading-one position from a combinational priority encoder.
  - Shift to 1.23 format.
  - Round to nearest even on the guard/sticky bits.
  - A mantissa carry-out increments the exponent.
  - A zero magnitude gives +0.
- DONE: register out, pulse done for one cycle, busy=0 on the same cycle, then return to IDLE.
- Normal-path latency: ITER+4 cycles from acceptance to done (28 at default). start may be accepted again on the cycle after done.
- Accuracy, normal inputs:
  - |ln x| >= 1: within 2 ulp.
  - |ln x| < 1: absolute error <= 2^-20.
  - Sign always correct: negative for x < 1, positive for x > 1.
- No exceptions or flags output.

Test Plan:
- Reset mid-ITER (assert rst at cycle 10 after start) -> busy=0, done=0, out=00000000, and no done pulse follows. Next start with in=40000000 -> out=3F317218 (ln 2) after 28 cycles, done high for exactly one cycle.
- Sweep of normal values:
  - in=41200000 (10) -> 40135D8E ±2 ulp
  - in=3DCCCCCD (0.1) -> C0135D8E ±2 ulp
  - in=402DF854 (e) -> 3F800000 ±2 ulp
  - in=3F000000 (0.5) -> BF317218 ±2 ulp
- Specials:
  - 3F800000 -> 00000000
  - 00000000 -> FF800000
  - 00000001 -> FF800000
  - BF000000 -> 7FC00000
  - 7F800000 -> 7F800000
  - 7FC00001 -> 7FC00000
  - each with done exactly 2 cycles after start.
- Busy protocol: second start pulse with in=41200000 during busy is ignored. The first result (in=40000000 -> 3F317218) is returned, then out holds 3F317218 with no further done until a new start in IDLE.
- Round-trip with taylor_exp: drive taylor_exp outputs for inputs 0.001, 0.01, 0.1, 10, 2, 1.53, 0.526, -0.526, -1.53 into in. Each out matches the original argument within 2^-20 absolute, or 2 ulp when |arg| >= 1.
- Back-to-back: start asserted on the cycle after done, with 3 consecutive operations -> each done spaced ITER+5 cycles apart and correct results in order.
